// File: rtl/seq_shifter.sv
// Multi-cycle shift engine: shifts a 16-bit operand one bit per clock
// with valid/ready handshakes on request and result, and reports the last bit shifted out.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_PASS = 2'b00;
  localparam logic [1:0]       OP_LSL  = 2'b01;
  localparam logic [1:0]       OP_LSR  = 2'b10;
  localparam logic [1:0]       OP_ASR  = 2'b11;
  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t           state_r;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] cnt_r;
  logic             carry_r;

  // One single-bit step; result is {carry_out, shifted_data}.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] op, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] res;
    case (op)
      OP_LSL:  res = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      OP_LSR:  res = {d[0], 1'b0, d[WIDTH-1:1]};
      OP_ASR:  res = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: res = {1'b0, d};
    endcase
    return res;
  endfunction

  assign out_data  = data_r;
  assign out_carry = carry_r;

  // Control FSM and datapath registers; handshake outputs are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      data_r    <= {WIDTH{1'b0}};
      op_r      <= OP_PASS;
      cnt_r     <= {AMT_W{1'b0}};
      carry_r   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r   <= in_data;
            op_r     <= in_op;
            cnt_r    <= in_amt;
            carry_r  <= 1'b0;
            in_ready <= 1'b0;
            if (in_op == OP_PASS || in_amt == {AMT_W{1'b0}}) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
            end else begin
              state_r   <= SHIFT;
              out_valid <= 1'b0;
            end
          end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          {carry_r, data_r} <= shift_step(op_r, data_r);
          cnt_r             <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
          end else begin
            state_r   <= SHIFT;
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: vector table plus hand sequences for
// backpressure and asynchronous reset in the middle of a shift.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] exp_data;
    logic        exp_carry;
    int          exp_n;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Called at the negedge after the accepting edge.
  task automatic wait_result(input string name, input int exp_n, input logic [15:0] ed, input logic ec);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, exp_n);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_carry"}, out_carry, ec);
  endtask

  task automatic handoff(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_after"}, out_valid, 1'b0);
    chk({name, "_ready_after"}, in_ready, 1'b1);
  endtask

  task automatic issue(input string name, input logic [15:0] d, input logic [1:0] op, input logic [3:0] amt);
    chk({name, "_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_amt   = amt;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_op    = 2'b01;
    in_amt   = 4'd9;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 2'b01, 4'd4,  16'h2340, 1'b1, 4};
    vecs[1] = '{16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 15};
    vecs[2] = '{16'h0003, 2'b10, 4'd1,  16'h0001, 1'b1, 1};
    vecs[3] = '{16'hBEEF, 2'b00, 4'd7,  16'hBEEF, 1'b0, 0};
    vecs[4] = '{16'hA5A5, 2'b01, 4'd0,  16'hA5A5, 1'b0, 0};
    vecs[5] = '{16'h8001, 2'b01, 4'd1,  16'h0002, 1'b1, 1};
    vecs[6] = '{16'h8001, 2'b10, 4'd15, 16'h0001, 1'b0, 15};
    vecs[7] = '{16'hF0F8, 2'b11, 4'd4,  16'hFF0F, 1'b1, 4};
    vecs[8] = '{16'h7FFF, 2'b11, 4'd3,  16'h0FFF, 1'b1, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_op = 2'b00; in_amt = 4'd0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_carry", out_carry, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", out_valid, 1'b0);

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(nm, vecs[i].data, vecs[i].op, vecs[i].amt);
      if (vecs[i].exp_n > 0) chk({nm, "_busy"}, in_ready, 1'b0);
      wait_result(nm, vecs[i].exp_n, vecs[i].exp_data, vecs[i].exp_carry);
      handoff(nm);
    end

    // Backpressure: request held on in_valid while busy and while result stalls.
    chk("bp_ready_before", in_ready, 1'b1);
    in_valid = 1'b1; in_data = 16'h00FF; in_op = 2'b01; in_amt = 4'd8;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'h0001; in_op = 2'b01; in_amt = 4'd1;
    chk("bp_busy", in_ready, 1'b0);
    wait_result("bp", 8, 16'hFF00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("bp_hold%0d_data", k), out_data, 16'hFF00);
      chk($sformatf("bp_hold%0d_ready", k), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_handoff_valid", out_valid, 1'b0);
    chk("bp_handoff_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", in_ready, 1'b0);
    wait_result("bp2", 1, 16'h0002, 1'b0);
    handoff("bp2");

    // Asynchronous reset two edges into a 10-step shift.
    issue("mid", 16'h0F0F, 2'b01, 4'd10);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 16'h0000);
    chk("mid_rst_carry", out_carry, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("mid_post%0d_valid", k), out_valid, 1'b0);
    end
    chk("mid_post_ready", in_ready, 1'b1);
    issue("after", 16'h0001, 2'b01, 4'd1);
    wait_result("after", 1, 16'h0002, 1'b0);
    handoff("after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
